// File: rtl/demux7_buf.sv
// demux7_buf: 1-to-7 demultiplexer with a one-word buffer per channel and invalid-select drop tracking
module demux7_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] dout0,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic [WIDTH-1:0] dout4,
    output logic [WIDTH-1:0] dout5,
    output logic [WIDTH-1:0] dout6,
    output logic [6:0]       out_valid,
    input  logic [6:0]       out_ready,
    output logic             err,
    output logic [7:0]       drop_cnt,
    output logic             busy
);
    logic [WIDTH-1:0] data [7];
    logic [7:0]       free;
    logic [7:0]       hit;
    // select 7 is a drop sink, so it can always accept
    assign free     = {1'b1, ~out_valid | out_ready};
    assign in_ready = free[s];
    assign hit      = (in_valid & in_ready) ? (8'd1 << s) : 8'd0;
    assign busy     = |out_valid;
    assign dout0    = data[0];
    assign dout1    = data[1];
    assign dout2    = data[2];
    assign dout3    = data[3];
    assign dout4    = data[4];
    assign dout5    = data[5];
    assign dout6    = data[6];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 7; k++) data[k] <= '0;
            out_valid <= '0;
            err       <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            for (int k = 0; k < 7; k++) begin
                if (hit[k]) data[k] <= din;
                out_valid[k] <= hit[k] | (out_valid[k] & ~out_ready[k]);
            end
            err      <= hit[7];
            drop_cnt <= drop_cnt + {7'd0, hit[7] && drop_cnt != 8'hFF};
        end
    end
endmodule

// File: tb/tb_demux7_buf.sv
// tb_demux7_buf: directed and random checks of demux7_buf against a per-channel queue model
module tb_demux7_buf;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] din = '0;
    logic [2:0]  s = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dout [7];
    logic [6:0]  out_valid;
    logic [6:0]  out_ready = '0;
    logic        err;
    logic [7:0]  drop_cnt;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] q [7][$];
    logic [31:0] last [7];
    logic        merr = 1'b0;
    int          mcnt = 0;
    bit          started = 1'b0;

    demux7_buf #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .din(din), .s(s), .in_valid(in_valid), .in_ready(in_ready),
        .dout0(dout[0]), .dout1(dout[1]), .dout2(dout[2]), .dout3(dout[3]),
        .dout4(dout[4]), .dout5(dout[5]), .dout6(dout[6]),
        .out_valid(out_valid), .out_ready(out_ready), .err(err), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state describes the DUT after the most recent rising edge
    initial begin
        logic [6:0] ev;
        logic       er;
        forever begin
            @(negedge clk);
            #3;
            er = (s == 3'd7) ? 1'b1 : (q[s].size() == 0 || out_ready[s]);
            if (started) begin
                for (int k = 0; k < 7; k++) begin
                    ev[k] = q[k].size() != 0;
                    chk($sformatf("model dout%0d", k), dout[k], ev[k] ? q[k][0] : last[k]);
                end
                chk("model out_valid", out_valid, ev);
                chk("model busy", busy, ev != 0);
                chk("model in_ready", in_ready, er);
                chk("model err", err, merr);
                chk("model drop_cnt", drop_cnt, mcnt);
            end
            if (reset) begin
                for (int k = 0; k < 7; k++) begin
                    q[k].delete();
                    last[k] = '0;
                end
                merr = 1'b0;
                mcnt = 0;
                started = 1'b1;
            end else if (started) begin
                for (int k = 0; k < 7; k++)
                    if (q[k].size() != 0 && out_ready[k]) last[k] = q[k].pop_front();
                merr = 1'b0;
                if (in_valid && er) begin
                    if (s == 3'd7) begin
                        merr = 1'b1;
                        if (mcnt < 255) mcnt++;
                    end else q[s].push_back(din);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic [31:0] d, input logic [2:0] sel, input logic v, input logic [6:0] ordy);
        @(negedge clk);
        #1;
        reset = r;
        din = d;
        s = sel;
        in_valid = v;
        out_ready = ordy;
        #1;
    endtask

    initial begin
        cyc(1, 32'h0, 0, 0, 7'h00);
        cyc(1, 32'hDEADBEEF, 5, 1, 7'h7F);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 32'h0, 3'(i), 0, 7'h00);
            chk("reset in_ready", in_ready, 1);
        end
        chk("reset out_valid", out_valid, 0);
        chk("reset drop_cnt", drop_cnt, 0);
        chk("reset busy", busy, 0);
        chk("reset dout5", dout[5], 0);

        cyc(0, 32'hA5A5A5A5, 3, 1, 7'h00);
        cyc(0, 32'h0, 0, 0, 7'h00);
        chk("push3 out_valid", out_valid, 7'b0001000);
        chk("push3 dout3", dout[3], 32'hA5A5A5A5);
        chk("push3 busy", busy, 1);
        chk("push3 dout0", dout[0], 0);
        cyc(0, 32'h0, 0, 0, 7'h7F);
        cyc(0, 32'h0, 0, 0, 7'h00);
        chk("pop3 out_valid", out_valid, 0);
        chk("pop3 dout3 retained", dout[3], 32'hA5A5A5A5);

        cyc(0, 32'h11111111, 2, 1, 7'h00);
        cyc(0, 32'h22222222, 2, 1, 7'h00);
        chk("full2 in_ready", in_ready, 0);
        cyc(0, 32'h22222222, 2, 1, 7'h04);
        chk("full2 dout2 held", dout[2], 32'h11111111);
        chk("popush2 in_ready", in_ready, 1);
        cyc(0, 32'h0, 0, 0, 7'h00);
        chk("popush2 dout2", dout[2], 32'h22222222);
        chk("popush2 out_valid", out_valid, 7'b0000100);
        cyc(0, 32'h0, 0, 0, 7'h7F);

        for (int k = 0; k < 7; k++) begin
            cyc(0, 32'h100 + k, 3'(k), 1, 7'h00);
            chk("fill in_ready", in_ready, 1);
        end
        cyc(0, 32'h0, 0, 0, 7'h7F);
        chk("fill out_valid", out_valid, 7'h7F);
        chk("fill dout6", dout[6], 32'h106);
        cyc(0, 32'h0, 0, 0, 7'h00);
        chk("drain out_valid", out_valid, 0);
        chk("drain busy", busy, 0);

        for (int i = 0; i < 260; i++) begin
            cyc(0, 32'hBAD00000 + i, 7, 1, 7'h00);
            if (i > 0) chk("drop err", err, 1);
        end
        cyc(0, 32'h0, 0, 0, 7'h00);
        chk("drop err last", err, 1);
        chk("drop drop_cnt", drop_cnt, 255);
        chk("drop out_valid", out_valid, 0);
        cyc(0, 32'h0, 0, 0, 7'h00);
        chk("drop err idle", err, 0);

        cyc(0, 32'h55550001, 1, 1, 7'h00);
        cyc(0, 32'h55550005, 5, 1, 7'h00);
        cyc(1, 32'h55550004, 4, 1, 7'h00);
        chk("prereset out_valid", out_valid, 7'b0100010);
        cyc(0, 32'h0, 0, 0, 7'h00);
        chk("midreset out_valid", out_valid, 0);
        chk("midreset drop_cnt", drop_cnt, 0);
        chk("midreset dout1", dout[1], 0);
        chk("midreset dout4", dout[4], 0);
        chk("midreset dout5", dout[5], 0);
        chk("midreset in_ready", in_ready, 1);

        for (int i = 0; i < 10000; i++)
            cyc(0, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 7'($urandom));
        cyc(0, 32'h0, 0, 0, 7'h00);
        @(negedge clk);
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
